// File: rtl/arch_map_table.sv
// Retirement-side architectural map table: commits update logical->physical mappings and
// free the displaced tags one cycle later; a recovery walk streams the map to rename.
module arch_map_table #(
  parameter int SIZE_LOGICAL      = 32,
  parameter int SIZE_LOGICAL_LOG  = 5,
  parameter int SIZE_PHYSICAL_LOG = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         commitValid0_i,
  input  logic                         commitValid1_i,
  input  logic                         commitValid2_i,
  input  logic                         commitValid3_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest0_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest1_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest2_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]  commitLogDest3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest3_i,
  input  logic                         recoverFlag_i,
  output logic                         freeValid0_o,
  output logic                         freeValid1_o,
  output logic                         freeValid2_o,
  output logic                         freeValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg3_o,
  output logic                         restoreValid_o,
  output logic [SIZE_LOGICAL_LOG-1:0]  restoreLogReg_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] restorePhyReg_o,
  output logic                         restoreBusy_o,
  output logic                         restoreDone_o
);

  localparam int LANES = 4;
  localparam int IDX_W = SIZE_LOGICAL_LOG + 1;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  typedef logic [SIZE_LOGICAL-1:0][SIZE_PHYSICAL_LOG-1:0] map_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < SIZE_LOGICAL; i++) m[i] = SIZE_PHYSICAL_LOG'(i);
    return m;
  endfunction

  state_t                                    state_q;
  logic [IDX_W-1:0]                          idx_q;
  map_t                                      map_q, map_d;
  logic [LANES-1:0]                          free_valid_q;
  logic [LANES-1:0][SIZE_PHYSICAL_LOG-1:0]   free_reg_q;
  logic                                      restore_valid_q;
  logic [SIZE_LOGICAL_LOG-1:0]               restore_log_q;
  logic [SIZE_PHYSICAL_LOG-1:0]              restore_phy_q;
  logic                                      restore_busy_q;
  logic                                      restore_done_q;

  logic [LANES-1:0]                          c_valid;
  logic [LANES-1:0][SIZE_LOGICAL_LOG-1:0]    c_log;
  logic [LANES-1:0][SIZE_PHYSICAL_LOG-1:0]   c_phy;
  logic [LANES-1:0][SIZE_PHYSICAL_LOG-1:0]   displaced;
  logic                                      accept;

  assign c_valid = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
  assign c_log   = {commitLogDest3_i, commitLogDest2_i, commitLogDest1_i, commitLogDest0_i};
  assign c_phy   = {commitPhyDest3_i, commitPhyDest2_i, commitPhyDest1_i, commitPhyDest0_i};

  // The walker owns the table while streaming; commits in that window are dropped.
  assign accept = (state_q != WALK);

  // Displaced tag: the youngest older lane to the same logical reg overrides the table.
  always_comb begin
    displaced = '0;
    for (int k = 0; k < LANES; k++) begin
      displaced[k] = map_q[c_log[k]];
      for (int j = 0; j < LANES; j++) begin
        if (j < k && c_valid[j] && c_log[j] == c_log[k]) displaced[k] = c_phy[j];
      end
    end
  end

  // Later lanes overwrite earlier ones, so the youngest writer of each reg wins.
  always_comb begin
    map_d = map_q;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (c_valid[k]) map_d[c_log[k]] = c_phy[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      map_q           <= identity_map();
      free_valid_q    <= '0;
      free_reg_q      <= '0;
      restore_valid_q <= 1'b0;
      restore_log_q   <= '0;
      restore_phy_q   <= '0;
      restore_busy_q  <= 1'b0;
      restore_done_q  <= 1'b0;
    end else begin
      map_q <= map_d;
      for (int k = 0; k < LANES; k++) begin
        free_valid_q[k] <= accept && c_valid[k];
        free_reg_q[k]   <= (accept && c_valid[k]) ? displaced[k] : '0;
      end
      restore_done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (recoverFlag_i) begin
            // Entry 0 goes out immediately from the post-commit table; idx_q is the next entry.
            state_q         <= WALK;
            idx_q           <= IDX_W'(1);
            restore_valid_q <= 1'b1;
            restore_busy_q  <= 1'b1;
            restore_log_q   <= '0;
            restore_phy_q   <= map_d[0];
          end else begin
            state_q         <= IDLE;
            idx_q           <= '0;
            restore_valid_q <= 1'b0;
            restore_busy_q  <= 1'b0;
            restore_log_q   <= '0;
            restore_phy_q   <= '0;
          end
        end
        WALK: begin
          if (idx_q == IDX_W'(SIZE_LOGICAL)) begin
            state_q         <= DONE;
            idx_q           <= '0;
            restore_valid_q <= 1'b0;
            restore_busy_q  <= 1'b0;
            restore_done_q  <= 1'b1;
            restore_log_q   <= '0;
            restore_phy_q   <= '0;
          end else begin
            restore_valid_q <= 1'b1;
            restore_busy_q  <= 1'b1;
            restore_log_q   <= idx_q[SIZE_LOGICAL_LOG-1:0];
            restore_phy_q   <= map_q[idx_q[SIZE_LOGICAL_LOG-1:0]];
            idx_q           <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freeValid0_o    = free_valid_q[0];
  assign freeValid1_o    = free_valid_q[1];
  assign freeValid2_o    = free_valid_q[2];
  assign freeValid3_o    = free_valid_q[3];
  assign freeReg0_o      = free_reg_q[0];
  assign freeReg1_o      = free_reg_q[1];
  assign freeReg2_o      = free_reg_q[2];
  assign freeReg3_o      = free_reg_q[3];
  assign restoreValid_o  = restore_valid_q;
  assign restoreLogReg_o = restore_log_q;
  assign restorePhyReg_o = restore_phy_q;
  assign restoreBusy_o   = restore_busy_q;
  assign restoreDone_o   = restore_done_q;

endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table: commit/free timing, intra-group forwarding,
// recovery walks, commits ignored mid-walk and reset during a walk.
module tb_arch_map_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       cv0, cv1, cv2, cv3;
  logic [4:0] cl0, cl1, cl2, cl3;
  logic [6:0] cp0, cp1, cp2, cp3;
  logic       recover;
  logic       fv0, fv1, fv2, fv3;
  logic [6:0] fr0, fr1, fr2, fr3;
  logic       r_valid, r_busy, r_done;
  logic [4:0] r_log;
  logic [6:0] r_phy;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_map [32];

  always #5 clk = ~clk;

  arch_map_table dut (
    .clk(clk), .reset(reset),
    .commitValid0_i(cv0), .commitValid1_i(cv1), .commitValid2_i(cv2), .commitValid3_i(cv3),
    .commitLogDest0_i(cl0), .commitLogDest1_i(cl1), .commitLogDest2_i(cl2), .commitLogDest3_i(cl3),
    .commitPhyDest0_i(cp0), .commitPhyDest1_i(cp1), .commitPhyDest2_i(cp2), .commitPhyDest3_i(cp3),
    .recoverFlag_i(recover),
    .freeValid0_o(fv0), .freeValid1_o(fv1), .freeValid2_o(fv2), .freeValid3_o(fv3),
    .freeReg0_o(fr0), .freeReg1_o(fr1), .freeReg2_o(fr2), .freeReg3_o(fr3),
    .restoreValid_o(r_valid), .restoreLogReg_o(r_log), .restorePhyReg_o(r_phy),
    .restoreBusy_o(r_busy), .restoreDone_o(r_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {cv0, cv1, cv2, cv3} = '0;
    {cl0, cl1, cl2, cl3} = '0;
    {cp0, cp1, cp2, cp3} = '0;
    recover = 1'b0;
  endtask

  task automatic lane(input int k, input logic [4:0] l, input logic [6:0] p);
    case (k)
      0: begin cv0 = 1'b1; cl0 = l; cp0 = p; end
      1: begin cv1 = 1'b1; cl1 = l; cp1 = p; end
      2: begin cv2 = 1'b1; cl2 = l; cp2 = p; end
      default: begin cv3 = 1'b1; cl3 = l; cp3 = p; end
    endcase
  endtask

  task automatic chk_free(input string tag, input logic [3:0] v,
                          input logic [6:0] r0, input logic [6:0] r1,
                          input logic [6:0] r2, input logic [6:0] r3);
    chk({tag, ".fv"}, {28'd0, fv3, fv2, fv1, fv0}, {28'd0, v});
    chk({tag, ".fr0"}, 32'(fr0), 32'(r0));
    chk({tag, ".fr1"}, 32'(fr1), 32'(r1));
    chk({tag, ".fr2"}, 32'(fr2), 32'(r2));
    chk({tag, ".fr3"}, 32'(fr3), 32'(r3));
  endtask

  task automatic init_identity();
    for (int i = 0; i < 32; i++) exp_map[i] = 7'(i);
  endtask

  // Caller has already driven recover (plus any coincident commit) before the edge.
  task automatic run_walk(input string tag, input bit inject,
                          input logic exp_fv0, input logic [6:0] exp_fr0);
    tick();
    clear_inputs();
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        chk({tag, ".coinc_fv0"}, 32'(fv0), 32'(exp_fv0));
        chk({tag, ".coinc_fr0"}, 32'(fr0), 32'(exp_fr0));
      end else begin
        chk({tag, ".walk_fv0"}, 32'(fv0), 32'd0);
      end
      chk({tag, ".valid"}, 32'(r_valid), 32'd1);
      chk({tag, ".busy"}, 32'(r_busy), 32'd1);
      chk({tag, ".done"}, 32'(r_done), 32'd0);
      chk({tag, ".log"}, 32'(r_log), 32'(i));
      chk({tag, ".phy"}, 32'(r_phy), 32'(exp_map[i]));
      if (inject) begin
        lane(0, 5'd2, 7'd90);
        recover = 1'b1;
      end
      tick();
    end
    chk({tag, ".end_valid"}, 32'(r_valid), 32'd0);
    chk({tag, ".end_busy"}, 32'(r_busy), 32'd0);
    chk({tag, ".end_done"}, 32'(r_done), 32'd1);
    chk({tag, ".end_fv0"}, 32'(fv0), 32'd0);
    clear_inputs();
    tick();
    chk({tag, ".post_done"}, 32'(r_done), 32'd0);
    chk({tag, ".post_valid"}, 32'(r_valid), 32'd0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #2;
    chk_free("rst", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("rst.valid", 32'(r_valid), 32'd0);
    chk("rst.busy", 32'(r_busy), 32'd0);
    chk("rst.done", 32'(r_done), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single commit, then a later commit to the same reg frees the earlier tag.
    lane(0, 5'd3, 7'd40);
    tick();
    clear_inputs();
    chk_free("c1", 4'b0001, 7'd3, 7'd0, 7'd0, 7'd0);
    tick();
    chk_free("c1_idle", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    lane(0, 5'd3, 7'd41);
    tick();
    clear_inputs();
    chk_free("c1_refree", 4'b0001, 7'd40, 7'd0, 7'd0, 7'd0);

    // Same-group dependency with a sparse lane pattern.
    lane(0, 5'd5, 7'd50);
    lane(2, 5'd5, 7'd60);
    tick();
    clear_inputs();
    chk_free("dep", 4'b0101, 7'd5, 7'd0, 7'd50, 7'd0);
    lane(3, 5'd5, 7'd61);
    tick();
    clear_inputs();
    chk_free("dep_map", 4'b1000, 7'd0, 7'd0, 7'd0, 7'd60);

    // Four distinct lanes from a fresh identity table.
    reset = 1'b1;
    #1;
    chk_free("rst2", 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    tick();
    reset = 1'b0;
    lane(0, 5'd1, 7'd70); lane(1, 5'd2, 7'd71); lane(2, 5'd3, 7'd72); lane(3, 5'd4, 7'd73);
    tick();
    clear_inputs();
    chk_free("quad", 4'b1111, 7'd1, 7'd2, 7'd3, 7'd4);
    lane(0, 5'd1, 7'd74); lane(1, 5'd2, 7'd75); lane(2, 5'd3, 7'd76); lane(3, 5'd4, 7'd77);
    tick();
    clear_inputs();
    chk_free("quad2", 4'b1111, 7'd70, 7'd71, 7'd72, 7'd73);

    // Recovery with a coincident commit to reg 7.
    init_identity();
    exp_map[1] = 7'd74; exp_map[2] = 7'd75; exp_map[3] = 7'd76; exp_map[4] = 7'd77;
    exp_map[7] = 7'd80;
    tick();
    lane(0, 5'd7, 7'd80);
    recover = 1'b1;
    run_walk("walk1", 1'b0, 1'b1, 7'd7);

    // Commits and recover requests driven mid-walk must be dropped.
    recover = 1'b1;
    run_walk("walk2", 1'b1, 1'b0, 7'd0);
    recover = 1'b1;
    run_walk("walk3", 1'b0, 1'b0, 7'd0);

    // Reset while entry 10 is on the bus.
    recover = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 10; i++) tick();
    chk("mid.log", 32'(r_log), 32'd10);
    reset = 1'b1;
    #1;
    chk("mid_rst.valid", 32'(r_valid), 32'd0);
    chk("mid_rst.busy", 32'(r_busy), 32'd0);
    chk("mid_rst.done", 32'(r_done), 32'd0);
    chk("mid_rst.log", 32'(r_log), 32'd0);
    chk("mid_rst.phy", 32'(r_phy), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("mid_rst.no_done", 32'(r_done), 32'd0);
      chk("mid_rst.no_valid", 32'(r_valid), 32'd0);
    end
    init_identity();
    recover = 1'b1;
    run_walk("walk4", 1'b0, 1'b0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arch_map_table.md
Name: arch_map_table

Overview:
- Retirement-side architectural register map table (AMT).
- Per commit group of up to 4 retiring instructions:
  - updates logical→physical mapping;
  - emits each displaced (previous) physical register, one cycle later, as the commitValidN_i/commitRegN_i push stream of the speculative free list.
- On recovery, a sequential walker streams the full architectural map to the rename map table for restore, one entry per cycle.

Parameters:
- SIZE_LOGICAL, 32, number of architectural registers.
- SIZE_LOGICAL_LOG, 5, log2(SIZE_LOGICAL).
- SIZE_PHYSICAL_LOG, 7, physical register tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- commitValid0_i..commitValid3_i  in  1 each  lane N retires an instruction with a destination register.
- commitLogDest0_i..commitLogDest3_i  in  SIZE_LOGICAL_LOG each  logical destination of lane N.
- commitPhyDest0_i..commitPhyDest3_i  in  SIZE_PHYSICAL_LOG each  new physical destination of lane N.
- recoverFlag_i  in  1  pipeline flush; start restore walk.
- freeValid0_o..freeValid3_o  out  1 each  displaced register valid (to free list commitValidN_i).
- freeReg0_o..freeReg3_o  out  SIZE_PHYSICAL_LOG each  displaced physical register (to free list commitRegN_i).
- restoreValid_o  out  1  restore entry valid this cycle.
- restoreLogReg_o  out  SIZE_LOGICAL_LOG  logical index being restored.
- restorePhyReg_o  out  SIZE_PHYSICAL_LOG  architectural mapping for restoreLogReg_o.
- restoreBusy_o  out  1  walker active; rename must stall.
- restoreDone_o  out  1  single-cycle pulse after last entry.

Behaviour:
- Reset (async, immediate):
  - map[i] = i for all i.
  - All outputs 0.
  - FSM = IDLE; walk index = 0.
- Commit update, evaluated every cycle:
  - Lanes are in program order, lane 0 oldest.
  - Displaced reg for lane k:
    - If an older valid lane j<k in the same cycle has the same logical dest, use commitPhyDest of the youngest such j (intra-group forwarding).
    - Otherwise use map[commitLogDestk_i] as registered before this edge.
  - Table write: for each logical reg, the youngest valid lane targeting it wins. Older same-dest lanes do not write.
- Free output timing:
  - freeValidN_o/freeRegN_o are registered: 1-cycle latency from commit.
  - Lane N in maps to lane N out; sparse patterns are preserved, because the free list packs them itself.
  - freeRegN_o = 0 when freeValidN_o = 0.
- FSM states:
  - IDLE:
    - Commits processed normally.
    - recoverFlag_i=1 → WALK, index=0.
    - Commits present in the same cycle as recoverFlag_i are applied to the table and freed before the walk begins.
  - WALK:
    - Each cycle: restoreValid_o=1, restoreLogReg_o=index, restorePhyReg_o=map[index], restoreBusy_o=1, index++.
    - The walk reads the post-update table.
    - Commit inputs are ignored, with no table write and no free output.
    - recoverFlag_i is ignored.
    - At index = SIZE_LOGICAL-1 → DONE.
  - DONE:
    - restoreDone_o=1 for one cycle; restoreBusy_o=0; restoreValid_o=0.
    - Commits are accepted this cycle.
    - Next state IDLE, or WALK if recoverFlag_i=1.
- Walk length and timing:
  - Walk length is exactly SIZE_LOGICAL cycles.
  - restoreBusy_o rises the cycle after recoverFlag_i.
- Width rules:
  - Index counter is SIZE_LOGICAL_LOG+1 bits internally; no wrap is used.
  - Outputs are truncated to port width.
- Reset mid-walk: the walk aborts immediately, the table returns to identity, and no restoreDone_o pulse is produced.
- Freed tags: the block does not check duplicate or invalid physical tags. Correctness of those tags belongs to the upstream active list.

Test Plan:
- Reset, then lane0 commit {log=3, phy=40} → next cycle freeValid0_o=1, freeReg0_o=3; later a commit to log 3 frees 40.
- Same-group dependency:
  - Stimulus: lane0 {log=5, phy=50}, lane2 {log=5, phy=60}, lane1 invalid.
  - Required: next cycle freeValid0/2=1; freeReg0_o=5, freeReg2_o=50, freeValid1_o=0; map[5]=60.
- Four-lane commit to distinct regs 1,2,3,4 with phys 70..73 → freeReg0..3_o = 1,2,3,4 all valid; table updated; a second group to the same regs frees 70..73.
- Recovery with coincident commit:
  - Stimulus: commit lane0 {log=7, phy=80} and recoverFlag_i=1 in the same cycle.
  - Required: freeReg0_o=7 next cycle; walk emits 32 entries over 32 cycles; entry 7 restorePhyReg_o=80, others are the current mapping.
  - Required: restoreDone_o pulses one cycle after the last entry.
- During WALK, drive commitValid0_i=1 {log=2, phy=90} → no free output, map[2] unchanged, as seen in the next walk.
- Assert reset at walk index 10 → all outputs 0 immediately, no restoreDone_o, map back to identity (verify via a new walk).
